// File: rtl/fc_intfc_spi_word_xfer_param.sv
// SPI slave word-transfer engine: moves one WORD_W-bit word per init/done handshake
// with configurable SPI mode, bit order and input synchroniser depth.
module fc_intfc_spi_word_xfer_param #(
  parameter int WORD_W      = 16,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk210_p,
  input  logic              reset_n_p,
  input  logic              spi_sck_p,
  input  logic              spi_ss_p,
  input  logic              spi_mosi_p,
  output logic              spi_miso_p,
  input  logic              spi_init_trans_p,
  input  logic [WORD_W-1:0] spi_tx_word_p,
  output logic [WORD_W-1:0] spi_rx_word_p,
  output logic              spi_word_done_p,
  output logic              spi_abort_p,
  output logic              spi_busy_p,
  output logic [2:0]        spi_state_dbg_p
);

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

  // Handshake: spi_init_trans_p high requests a word; spi_word_done_p rises when the
  // word is complete and stays high until spi_init_trans_p is dropped.
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_WAIT_LEAD  = 3'd2,
    S_WAIT_TRAIL = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  state_t state, state_n;

  // Asynchronous assert, synchronous release of the internal reset.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk210_p or negedge reset_n_p) begin
    if (!reset_n_p) rst_sync <= 2'b00;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, ss_sync;
  logic                   sck_hist;
  logic                   sck_s, mosi_s, ss_s;
  logic                   lead_edge, trail_edge;

  always_ff @(posedge clk210_p or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= {SYNC_STAGES{CPOL}};
      mosi_sync <= '0;
      ss_sync   <= '1;
      sck_hist  <= CPOL;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck_p};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_p};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_p};
      sck_hist  <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s      = sck_sync[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync[SYNC_STAGES-1];
  assign ss_s       = ss_sync[SYNC_STAGES-1];
  assign lead_edge  = (sck_s != sck_hist) && (sck_s != CPOL);
  assign trail_edge = (sck_s != sck_hist) && (sck_s == CPOL);

  logic [WORD_W-1:0] tx_sr, rx_sr, rx_sr_next, tx_sr_shifted;
  logic [CNT_W-1:0]  bit_cnt;
  logic              tx_out;

  assign tx_out        = MSB_FIRST ? tx_sr[WORD_W-1] : tx_sr[0];
  assign tx_sr_shifted = MSB_FIRST ? {tx_sr[WORD_W-2:0], 1'b0} : {1'b0, tx_sr[WORD_W-1:1]};
  assign rx_sr_next    = MSB_FIRST ? {rx_sr[WORD_W-2:0], mosi_s} : {mosi_s, rx_sr[WORD_W-1:1]};

  logic load_tx, tx_shift, rx_shift, complete, abort_n, clr_done;

  always_ff @(posedge clk210_p or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    load_tx  = 1'b0;
    tx_shift = 1'b0;
    rx_shift = 1'b0;
    complete = 1'b0;
    abort_n  = 1'b0;
    clr_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (spi_init_trans_p && !ss_s) begin
          load_tx = 1'b1;
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        if (ss_s) begin
          state_n = S_IDLE;
        end else begin
          tx_shift = !CPHA;
          state_n  = S_WAIT_LEAD;
        end
      end
      S_WAIT_LEAD: begin
        if (ss_s) begin
          abort_n = 1'b1;
          state_n = S_IDLE;
        end else if (lead_edge) begin
          tx_shift = CPHA;
          rx_shift = !CPHA;
          state_n  = S_WAIT_TRAIL;
        end
      end
      S_WAIT_TRAIL: begin
        if (ss_s) begin
          abort_n = 1'b1;
          state_n = S_IDLE;
        end else if (trail_edge) begin
          if (CPHA) begin
            rx_shift = 1'b1;
            complete = (bit_cnt == CNT_LAST);
          end else begin
            tx_shift = (bit_cnt < CNT_FULL);
            complete = (bit_cnt == CNT_FULL);
          end
          state_n = complete ? S_DONE : S_WAIT_LEAD;
        end
      end
      S_DONE: begin
        if (ss_s || !spi_init_trans_p) begin
          clr_done = 1'b1;
          state_n  = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // With CPHA=1 the final bit is captured on the completing edge itself,
  // so the published word must include it.
  always_ff @(posedge clk210_p or negedge rst_n) begin
    if (!rst_n) begin
      tx_sr           <= '0;
      rx_sr           <= '0;
      bit_cnt         <= '0;
      spi_miso_p      <= 1'b0;
      spi_rx_word_p   <= '0;
      spi_word_done_p <= 1'b0;
      spi_abort_p     <= 1'b0;
    end else begin
      spi_abort_p <= abort_n;
      if (load_tx) begin
        tx_sr   <= spi_tx_word_p;
        bit_cnt <= '0;
      end
      if (tx_shift) begin
        spi_miso_p <= tx_out;
        tx_sr      <= tx_sr_shifted;
      end
      if (rx_shift) begin
        rx_sr   <= rx_sr_next;
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (complete) begin
        spi_rx_word_p   <= CPHA ? rx_sr_next : rx_sr;
        spi_word_done_p <= 1'b1;
      end
      if (abort_n) bit_cnt <= '0;
      if (clr_done || abort_n) spi_word_done_p <= 1'b0;
    end
  end

  assign spi_busy_p      = (state == S_LOAD) || (state == S_WAIT_LEAD) || (state == S_WAIT_TRAIL);
  assign spi_state_dbg_p = state;

endmodule

// File: tb/tb_fc_intfc_spi_word_xfer_param.sv
// Bench for the SPI word-transfer engine: a mode-0 MSB-first 16-bit instance and a
// mode-3 LSB-first 8-bit instance, each driven by an FC master model.
module tb_fc_intfc_spi_word_xfer_param;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  logic        a_sck = 1'b0, a_ss = 1'b1, a_mosi = 1'b0, a_init = 1'b0;
  logic [15:0] a_tx = '0;
  logic        a_miso, a_done, a_abort, a_busy;
  logic [15:0] a_rx;
  logic [2:0]  a_dbg;

  logic        b_sck = 1'b1, b_ss = 1'b1, b_mosi = 1'b0, b_init = 1'b0;
  logic [7:0]  b_tx = '0;
  logic        b_miso, b_done, b_abort, b_busy;
  logic [7:0]  b_rx;
  logic [2:0]  b_dbg;

  fc_intfc_spi_word_xfer_param #(
    .WORD_W(16), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1), .SYNC_STAGES(2)
  ) dut_a (
    .clk210_p(clk), .reset_n_p(rst_n), .spi_sck_p(a_sck), .spi_ss_p(a_ss),
    .spi_mosi_p(a_mosi), .spi_miso_p(a_miso), .spi_init_trans_p(a_init),
    .spi_tx_word_p(a_tx), .spi_rx_word_p(a_rx), .spi_word_done_p(a_done),
    .spi_abort_p(a_abort), .spi_busy_p(a_busy), .spi_state_dbg_p(a_dbg)
  );

  fc_intfc_spi_word_xfer_param #(
    .WORD_W(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0), .SYNC_STAGES(3)
  ) dut_b (
    .clk210_p(clk), .reset_n_p(rst_n), .spi_sck_p(b_sck), .spi_ss_p(b_ss),
    .spi_mosi_p(b_mosi), .spi_miso_p(b_miso), .spi_init_trans_p(b_init),
    .spi_tx_word_p(b_tx), .spi_rx_word_p(b_rx), .spi_word_done_p(b_done),
    .spi_abort_p(b_abort), .spi_busy_p(b_busy), .spi_state_dbg_p(b_dbg)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: every distinct value rx_word takes, in order.
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  logic [15:0] a_model_rx = '0;
  logic [15:0] a_rx_prev = '0;
  logic        a_done_prev = 1'b0;
  bit          mon_en = 1'b0;
  int          a_abort_cnt = 0;
  int          a_done_rises = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (a_rx !== a_rx_prev) begin
        got_q.push_back(a_rx);
        a_rx_prev = a_rx;
      end
      if (a_abort === 1'b1) a_abort_cnt++;
      if (a_done === 1'b1 && a_done_prev !== 1'b1) a_done_rises++;
      a_done_prev = a_done;
    end
  end

  task automatic a_expect_rx(input logic [15:0] v);
    if (v !== a_model_rx) begin
      exp_q.push_back(v);
      a_model_rx = v;
    end
  endtask

  // FC master, mode 0 MSB first: data set while SCK low, both sides sample on rise.
  task automatic a_word(input logic [15:0] tx, input logic [15:0] fc_word, input int h,
                        input int nbits, input int pre, output logic [15:0] fc_got);
    a_tx = tx;
    a_init = 1'b1;
    a_ss = 1'b0;
    fc_got = '0;
    repeat (pre) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      a_mosi = fc_word[15-i];
      repeat (h) @(negedge clk);
      a_sck = 1'b1;
      fc_got[15-i] = a_miso;
      repeat (h) @(negedge clk);
      a_sck = 1'b0;
    end
  endtask

  // FC master, mode 3 LSB first: data changes on the falling (leading) edge, sampled on rise.
  task automatic b_word(input logic [7:0] tx, input logic [7:0] fc_word, input int h,
                        output logic [7:0] fc_got);
    b_tx = tx;
    b_init = 1'b1;
    b_ss = 1'b0;
    fc_got = '0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      b_sck = 1'b0;
      b_mosi = fc_word[i];
      repeat (h) @(negedge clk);
      b_sck = 1'b1;
      fc_got[i] = b_miso;
      repeat (h) @(negedge clk);
    end
  endtask

  task automatic a_wait_done(input string name);
    int n = 0;
    while (a_done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (a_done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout got=%b exp=1", name, a_done);
    end
  endtask

  task automatic b_wait_done(input string name);
    int n = 0;
    while (b_done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (b_done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout got=%b exp=1", name, b_done);
    end
  endtask

  task automatic a_release();
    a_init = 1'b0;
    repeat (2) @(negedge clk);
    a_ss = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic b_release();
    b_init = 1'b0;
    repeat (2) @(negedge clk);
    b_ss = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_rx, a_done, a_abort, a_busy, a_miso} !== 20'h0) begin
      errors++;
      $display("FAIL reset_a got=%h exp=0", {a_rx, a_done, a_abort, a_busy, a_miso});
    end
    checks++;
    if ({b_rx, b_done, b_abort, b_busy, b_miso} !== 12'h0) begin
      errors++;
      $display("FAIL reset_b got=%h exp=0", {b_rx, b_done, b_abort, b_busy, b_miso});
    end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    mon_en = 1'b1;
    checks++;
    if ({a_done, a_busy, b_done, b_busy} !== 4'h0) begin
      errors++;
      $display("FAIL reset_release got=%h exp=0", {a_done, a_busy, b_done, b_busy});
    end
  endtask

  task automatic test_mode0_basic();
    logic [15:0] got;
    int ab0 = a_abort_cnt;
    a_word(16'hA5C3, 16'h1234, 10, 16, 8, got);
    a_wait_done("mode0");
    a_expect_rx(16'h1234);
    checks++;
    if (got !== 16'hA5C3) begin errors++; $display("FAIL mode0_miso got=%h exp=a5c3", got); end
    checks++;
    if (a_rx !== 16'h1234) begin errors++; $display("FAIL mode0_rx got=%h exp=1234", a_rx); end
    repeat (20) @(negedge clk);
    checks++;
    if (a_done !== 1'b1) begin errors++; $display("FAIL mode0_done_hold got=%b exp=1", a_done); end
    a_init = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_done, a_busy} !== 2'b00) begin
      errors++;
      $display("FAIL mode0_done_drop got=%b exp=00", {a_done, a_busy});
    end
    a_release();
    checks++;
    if (a_abort_cnt !== ab0) begin errors++; $display("FAIL mode0_no_abort got=%0d exp=%0d", a_abort_cnt, ab0); end
  endtask

  task automatic test_mode3_lsb();
    logic [7:0] got;
    b_word(8'h81, 8'h3C, 10, got);
    b_wait_done("mode3");
    checks++;
    if (got !== 8'h81) begin errors++; $display("FAIL mode3_miso got=%h exp=81", got); end
    checks++;
    if (b_rx !== 8'h3C) begin errors++; $display("FAIL mode3_rx got=%h exp=3c", b_rx); end
    b_release();
    checks++;
    if (b_done !== 1'b0) begin errors++; $display("FAIL mode3_done_drop got=%b exp=0", b_done); end
  endtask

  task automatic test_abort();
    logic [15:0] got;
    int ab0;
    a_word(16'h0000, 16'hBEEF, 10, 16, 8, got);
    a_wait_done("abort_pre");
    a_expect_rx(16'hBEEF);
    a_release();
    ab0 = a_abort_cnt;
    a_word(16'h6789, 16'h1111, 10, 9, 8, got);
    a_ss = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (a_abort_cnt !== ab0 + 1) begin
      errors++;
      $display("FAIL abort_pulse got=%0d exp=%0d", a_abort_cnt - ab0, 1);
    end
    checks++;
    if ({a_rx, a_done, a_busy} !== {16'hBEEF, 2'b00}) begin
      errors++;
      $display("FAIL abort_state got=%h exp=%h", {a_rx, a_done, a_busy}, {16'hBEEF, 2'b00});
    end
    a_init = 1'b0;
    repeat (2) @(negedge clk);
    a_word(16'h3C3C, 16'h0F0F, 10, 16, 8, got);
    a_wait_done("abort_next");
    a_expect_rx(16'h0F0F);
    checks++;
    if ({a_rx, got} !== {16'h0F0F, 16'h3C3C}) begin
      errors++;
      $display("FAIL abort_next got=%h exp=%h", {a_rx, got}, {16'h0F0F, 16'h3C3C});
    end
    a_release();
  endtask

  task automatic test_reset_mid();
    logic [15:0] got;
    int ab0, dr0;
    a_word(16'h1357, 16'hAAAA, 10, 5, 8, got);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_rx, a_done, a_abort, a_busy, a_miso} !== 20'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs got=%h exp=0", {a_rx, a_done, a_abort, a_busy, a_miso});
    end
    a_expect_rx(16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    a_init = 1'b0;
    a_ss = 1'b1;
    ab0 = a_abort_cnt;
    dr0 = a_done_rises;
    repeat (8) @(negedge clk);
    checks++;
    if ({a_abort_cnt, a_done_rises} !== {ab0, dr0}) begin
      errors++;
      $display("FAIL reset_mid_quiet got=%0d/%0d exp=%0d/%0d", a_abort_cnt, a_done_rises, ab0, dr0);
    end
    a_word(16'h9A5E, 16'hFFFF, 10, 16, 8, got);
    a_wait_done("reset_next");
    a_expect_rx(16'hFFFF);
    checks++;
    if ({a_rx, got} !== {16'hFFFF, 16'h9A5E}) begin
      errors++;
      $display("FAIL reset_next got=%h exp=%h", {a_rx, got}, {16'hFFFF, 16'h9A5E});
    end
    a_release();
  endtask

  task automatic test_back_to_back();
    logic [15:0] words[3];
    logic [15:0] got, tx;
    int dr0 = a_done_rises;
    words[0] = 16'h0001;
    words[1] = 16'h8000;
    words[2] = 16'h5555;
    for (int k = 0; k < 3; k++) begin
      tx = 16'($urandom);
      a_word(tx, words[k], 10, 16, (k == 0) ? 8 : 1, got);
      a_wait_done("b2b");
      a_expect_rx(words[k]);
      checks++;
      if ({a_rx, got} !== {words[k], tx}) begin
        errors++;
        $display("FAIL b2b_word%0d got=%h exp=%h", k, {a_rx, got}, {words[k], tx});
      end
      a_init = 1'b0;
      @(negedge clk);
    end
    a_release();
    checks++;
    if (a_done_rises !== dr0 + 3) begin
      errors++;
      $display("FAIL b2b_done_count got=%0d exp=3", a_done_rises - dr0);
    end
  endtask

  task automatic test_fast_sck();
    logic [15:0] got, w;
    for (int k = 0; k < 3; k++) begin
      w = 16'($urandom);
      a_word(16'($urandom), w, 2, 16, 8, got);
      a_wait_done("fast");
      a_expect_rx(w);
      checks++;
      if (a_rx !== w) begin errors++; $display("FAIL fast_rx got=%h exp=%h", a_rx, w); end
      a_release();
    end
  endtask

  task automatic test_random();
    logic [15:0] ga, ta, wa;
    logic [7:0]  gb, tb, wb;
    int h;
    for (int k = 0; k < 6; k++) begin
      ta = 16'($urandom);
      wa = 16'($urandom);
      h = $urandom_range(6, 12);
      a_word(ta, wa, h, 16, 8, ga);
      a_wait_done("rand_a");
      a_expect_rx(wa);
      checks++;
      if ({a_rx, ga} !== {wa, ta}) begin
        errors++;
        $display("FAIL rand_a got=%h exp=%h", {a_rx, ga}, {wa, ta});
      end
      a_release();
      tb = 8'($urandom);
      wb = 8'($urandom);
      b_word(tb, wb, $urandom_range(7, 12), gb);
      b_wait_done("rand_b");
      checks++;
      if ({b_rx, gb} !== {wb, tb}) begin
        errors++;
        $display("FAIL rand_b got=%h exp=%h", {b_rx, gb}, {wb, tb});
      end
      b_release();
    end
  endtask

  task automatic test_scoreboard();
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL rx_history_len got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rx_history[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode0_basic();
    test_mode3_lsb();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_fast_sck();
    test_random();
    test_scoreboard();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
